// File: rtl/nibble_ser_pkg.sv
// Shared types and index helpers for the nibble serializer.
// Index helpers take the word/slice geometry so the top can size its counter at elaboration.
package nibble_ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int num_slices(input int word_w, input int nib_w);
    return word_w / nib_w;
  endfunction

  // MSB-first walks down from the top bit using -: selects; LSB-first walks up from bit 0 using +:.
  function automatic int start_idx(input int word_w, input int nib_w, input bit msb_first);
    return msb_first ? (word_w - 1) : 0;
  endfunction

  function automatic int final_idx(input int word_w, input int nib_w, input bit msb_first);
    return msb_first ? (nib_w - 1) : (word_w - nib_w);
  endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Word-to-nibble serializer: accepts a WORD_W word on a valid/ready stream and
// emits WORD_W/NIB_W slices one per cycle, flagging the final slice with out_last.
//
// state | meaning
// IDLE  | no word held; in_ready=1, outputs quiet
// SHIFT | presenting word_q slice at idx_q; advances on each out fire
import nibble_ser_pkg::*;

module nibble_serializer #(
  parameter int WORD_W    = 16,
  parameter int NIB_W     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIB_W-1:0]  out_nibble,
  output logic              out_last
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(start_idx(WORD_W, NIB_W, MSB_FIRST));
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(final_idx(WORD_W, NIB_W, MSB_FIRST));
  localparam logic [IDX_W-1:0] STEP      = IDX_W'(NIB_W);

  if (NIB_W <= 0 || WORD_W <= 0 || (WORD_W % NIB_W) != 0 ||
      num_slices(WORD_W, NIB_W) * NIB_W != WORD_W) begin : g_bad_geometry
    $error("nibble_serializer: WORD_W (%0d) must be a positive multiple of NIB_W (%0d)",
           WORD_W, NIB_W);
  end

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NIB_W-1:0]  slice;
  logic              at_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= START_IDX;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    slice = '0;
    if (MSB_FIRST) slice = word_q[idx_q -: NIB_W];
    else           slice = word_q[idx_q +: NIB_W];
  end

  assign at_final = (idx_q == FINAL_IDX);

  // in_ready depends combinationally on out_ready in SHIFT so the next word
  // can be taken on the same edge the final slice leaves: no bubble between words.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_nibble = '0;
    out_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = START_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid  = 1'b1;
        out_nibble = slice;
        out_last   = at_final;
        in_ready   = at_final && out_ready;
        if (out_ready) begin
          if (!at_final) begin
            idx_d = MSB_FIRST ? (idx_q - STEP) : (idx_q + STEP);
          end else if (in_valid) begin
            word_d = in_data;
            idx_d  = START_IDX;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: MSB-first and LSB-first instances share stimulus,
// with per-cycle checks plus a scoreboard of expected nibbles popped on every out fire.
module tb_nibble_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_out_last;
  logic [3:0]  m_out_nibble;
  logic        l_in_ready, l_out_valid, l_out_last;
  logic [3:0]  l_out_nibble;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] q_m[$];
  logic [15:0] q_l[$];

  always #5 clk = ~clk;

  nibble_serializer #(.WORD_W(16), .NIB_W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_nibble(m_out_nibble), .out_last(m_out_last)
  );

  nibble_serializer #(.WORD_W(16), .NIB_W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_nibble(l_out_nibble), .out_last(l_out_last)
  );

  function automatic logic [3:0] nib_model(input logic [15:0] w, input int i, input bit msb);
    logic [15:0] s;
    s = msb ? (w >> (12 - 4 * i)) : (w >> (4 * i));
    return s[3:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      q_m.push_back({11'b0, (i == 3), nib_model(w, i, 1'b1)});
      q_l.push_back({11'b0, (i == 3), nib_model(w, i, 1'b0)});
    end
  endtask

  task automatic check_slice(input string tag, input logic [15:0] w, input int i, input logic rdy_exp);
    check({tag, "_m_valid"}, 16'(m_out_valid), 16'd1);
    check({tag, "_m_nib"},   16'(m_out_nibble), 16'(nib_model(w, i, 1'b1)));
    check({tag, "_m_last"},  16'(m_out_last), 16'(i == 3));
    check({tag, "_m_ready"}, 16'(m_in_ready), 16'(rdy_exp));
    check({tag, "_l_valid"}, 16'(l_out_valid), 16'd1);
    check({tag, "_l_nib"},   16'(l_out_nibble), 16'(nib_model(w, i, 1'b0)));
    check({tag, "_l_last"},  16'(l_out_last), 16'(i == 3));
    check({tag, "_l_ready"}, 16'(l_in_ready), 16'(rdy_exp));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_valid"}, 16'(m_out_valid), 16'd0);
    check({tag, "_m_nib"},   16'(m_out_nibble), 16'd0);
    check({tag, "_m_last"},  16'(m_out_last), 16'd0);
    check({tag, "_m_ready"}, 16'(m_in_ready), 16'd1);
    check({tag, "_l_valid"}, 16'(l_out_valid), 16'd0);
    check({tag, "_l_nib"},   16'(l_out_nibble), 16'd0);
    check({tag, "_l_ready"}, 16'(l_in_ready), 16'd1);
  endtask

  // Scoreboard: every fire must match the oldest expected slice; 16'hFFFF marks an unexpected fire.
  always @(negedge clk) begin
    logic [15:0] exp_v;
    if (m_out_valid && out_ready) begin
      exp_v = (q_m.size() != 0) ? q_m.pop_front() : 16'hFFFF;
      check("sb_msb", {11'b0, m_out_last, m_out_nibble}, exp_v);
    end
    if (l_out_valid && out_ready) begin
      exp_v = (q_l.size() != 0) ? q_l.pop_front() : 16'hFFFF;
      check("sb_lsb", {11'b0, l_out_last, l_out_nibble}, exp_v);
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    #2;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle gating
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // single word A5C3
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hA5C3; push_word(16'hA5C3, 4);
    @(negedge clk);
    check("single_accept_ready", 16'(m_in_ready), 16'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_slice("single", 16'hA5C3, i, (i == 3));
    end
    @(negedge clk);
    check_idle("single_done");

    // backpressure on the second slice of 1234
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h1234; push_word(16'h1234, 4);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_slice("bp_first", 16'h1234, 0, 1'b0);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_slice("bp_hold", 16'h1234, 1, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_slice("bp_rest", 16'h1234, i, (i == 3));
    end
    @(negedge clk);
    check_idle("bp_done");

    // back-to-back DEAD then BEEF with no bubble
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hDEAD; push_word(16'hDEAD, 4);
    @(posedge clk); #1;
    in_data = 16'hBEEF; push_word(16'hBEEF, 4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_slice("b2b", (i < 4) ? 16'hDEAD : 16'hBEEF, i % 4, (i % 4 == 3));
      if (i == 3) begin
        @(posedge clk); #1 in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("b2b_done");

    // reset after two slices of FACE: rest must be discarded
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hFACE; push_word(16'hFACE, 2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_slice("rst_mid0", 16'hFACE, 0, 1'b0);
    @(negedge clk);
    check_slice("rst_mid1", 16'hFACE, 1, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_idle("rst_mid_asserted");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_idle("rst_mid_after");
    end

    check("sb_msb_drained", 16'(q_m.size()), 16'd0);
    check("sb_lsb_drained", 16'(q_l.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
